logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, two-stage pipelined logic unit with valid/ready handshaking, eight operations and status flags. It replaces the single-register logic slice inside the hierarchical ALU. It sits between the ALU operand/decode stage and the ALU result mux, and sustains one operation per cycle under back-pressure.

## Interface
- `IN_WIDTH`, default 8: operand width; must be ≥ 2.
- `OUT_WIDTH`, default 16: result width; must be ≥ `IN_WIDTH`. Results are zero-extended.
- `CNT_WIDTH`, default 16: width of the completed-operation counter.
- `clk` input, 1: single clock; all state is updated on the rising edge.
- `RST` input, 1: asynchronous, active-low reset.
- `A`, `B` input, `IN_WIDTH`: operands.
- `ALU_FUN` input, 3: operation select.
- `in_valid` input, 1: operands and `ALU_FUN` are valid this cycle.
- `in_ready` output, 1: the block accepts the operation this cycle.
- `Logic_OUT` output, `OUT_WIDTH`: registered result.
- `Logic_Flag` output, 1: `Logic_OUT` and the flags hold a valid result (out_valid).
- `out_ready` input, 1: downstream consumes the result this cycle.
- `Zero_Flag` output, 1: the result is all zeros.
- `Illegal_Flag` output, 1: the op was not legal in this build; the result is forced to 0.
- `Op_Count` output, `CNT_WIDTH`: number of results consumed since reset.

## Operation
- Op codes:
  - 000: AND
  - 001: OR
  - 010: NAND
  - 011: NOR
  - 100: XOR
  - 101: XNOR
  - 110: SHL — A shifted left by `B[$clog2(IN_WIDTH)-1:0]`
  - 111: ROR — A rotated right by the same amount
- All ops are computed at `IN_WIDTH`, then zero-extended to `OUT_WIDTH`. NAND, NOR and XNOR inversion applies only to the low `IN_WIDTH` bits; the upper bits stay 0.
- SHL discards bits shifted out beyond `IN_WIDTH`. A shift or rotate amount of 0 passes A through unchanged.
- A transfer occurs in any cycle where `in_valid && in_ready`.
- Stage 1 (S1) registers A, B and `ALU_FUN`, and holds its own valid bit.
- Stage 2 (S2) computes the op from S1 and registers `Logic_OUT`, `Zero_Flag` and `Illegal_Flag`. The S2 valid bit drives `Logic_Flag`.
- Stage advance rules:
  - S2 loads when `!Logic_Flag || out_ready`.
  - S1 loads when `!s1_valid || s2_loads`.
  - `in_ready = !s1_valid || s2_loads`. This path is combinational from `out_ready`.
- While `Logic_Flag` is high and `out_ready` is low, the S2 outputs are held stable bit-for-bit.
- `Op_Count` increments by 1 on every `Logic_Flag && out_ready` cycle and wraps modulo 2^`CNT_WIDTH`.
- Reset values: `Logic_OUT` = 0, `Zero_Flag` = 0, `Illegal_Flag` = 0, `Logic_Flag` = 0, `Op_Count` = 0, S1 valid = 0. `in_ready` is therefore 1 immediately after reset.
- Reset asserted mid-operation: all in-flight operations are dropped and nothing is replayed.

## Timing
- Latency: an op accepted at edge N appears on `Logic_OUT` with `Logic_Flag` = 1 after edge N+2.
- Throughput is 1 op per cycle when `out_ready` is held high.
- Back-pressure: with `out_ready` low, the pipe holds 2 ops. `in_ready` drops in the cycle after the second op is accepted.
- On a simultaneous output drain and input accept with the pipe full, both stages shift in the same edge and no bubble is inserted.
- `in_valid` low with `in_ready` high: no transfer and no state change, apart from draining.

## Configuration
- Macro: `LOGIC_UNIT_PIPE_SHIFT_EN`.
- Defined: 110 and 111 perform SHL and ROR as specified, and `Illegal_Flag` is always 0.
- Undefined: the barrel shifter is not built. Codes 110 and 111 produce `Logic_OUT` = 0, `Zero_Flag` = 1 and `Illegal_Flag` = 1. The handshake, latency and counter behave exactly as in the defined build.

## Structure
- Package `logic_unit_pkg` holds:
  - the 3-bit op-code enum (`LU_AND` … `LU_ROR`)
  - the `OP_W` = 3 constant
  - the result struct {data, zero, illegal}.
- Sub-module `logic_unit_core`: purely combinational op evaluation (op, A, B → result struct), parametrised by `IN_WIDTH` and `OUT_WIDTH`. It is instantiated once, between S1 and S2.
- The top level contains only the pipeline registers, the handshake logic and the counter.

## Test plan
- Reset then single op (defaults): A=8'hF0, B=8'h3C, op=100, `out_ready`=1.
  - Expect `Logic_OUT`=16'h00CC, `Logic_Flag` high 2 cycles after acceptance, `Op_Count`=1.
- Inversion width (defaults): A=8'hFF, B=8'hFF, op=011 (NOR).
  - Expect `Logic_OUT`=16'h0000, `Zero_Flag`=1. The upper byte must not be 8'hFF.
- Back-pressure: stream 4 ops with `out_ready`=0.
  - Expect `in_ready` to drop after 2 accepts and `Logic_OUT` to hold.
  - Release `out_ready`: expect results in order at 1 per cycle and `Op_Count`=4.
- Shift/rotate with the macro defined: A=8'h81, B=8'h01.
  - op=110 → 16'h0002.
  - op=111 → 16'h00C0.
  - Same ops without the macro → 0, with `Zero_Flag`=1 and `Illegal_Flag`=1.
- Mid-operation reset: pulse `RST` low with both stages full.
  - Expect all outputs = 0 immediately (asynchronously), no stale result after release, and `in_ready`=1.
- Counter wrap with `CNT_WIDTH`=2: consume 5 results.
  - Expect `Op_Count` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op-code enum, op-code width and
// the combinational result bundle passed from logic_unit_core to the S2 registers.
// Result data is carried at a fixed maximum width; users take the low OUT_WIDTH bits.
package logic_unit_pkg;

   localparam int OP_W     = 3;
   // Upper bound on OUT_WIDTH for any instance of logic_unit_pipe.
   localparam int LU_MAX_W = 128;

   typedef enum logic [OP_W-1:0] {
      LU_AND  = 3'b000,
      LU_OR   = 3'b001,
      LU_NAND = 3'b010,
      LU_NOR  = 3'b011,
      LU_XOR  = 3'b100,
      LU_XNOR = 3'b101,
      LU_SHL  = 3'b110,
      LU_ROR  = 3'b111
   } lu_op_e;

   typedef struct packed {
      logic [LU_MAX_W-1:0] data;
      logic                zero;
      logic                illegal;
   } lu_result_t;

endpackage

// File: rtl/logic_unit_core.sv
// Purpose : combinational evaluation of one logic-unit op (op, a, b -> result).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; the surrounding pipeline decides when the result is captured.
// Ports   : op (lu_op_e), a/b (IN_WIDTH operands), res (lu_result_t, data zero-extended
//           to OUT_WIDTH, zero flag, illegal flag).
// Config  : LOGIC_UNIT_PIPE_SHIFT_EN builds the SHL/ROR barrel shifter; without it
//           SHL/ROR return 0 with the illegal flag set.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16
) (
   input  lu_op_e              op,
   input  logic [IN_WIDTH-1:0] a,
   input  logic [IN_WIDTH-1:0] b,
   output lu_result_t          res
);

   logic [IN_WIDTH-1:0] r;
   logic                ill;

`ifdef LOGIC_UNIT_PIPE_SHIFT_EN
   localparam int SH_W = $clog2(IN_WIDTH);
   logic [SH_W-1:0] sh;
   assign sh = b[SH_W-1:0];
`endif

   always_comb begin
      r   = '0;
      ill = 1'b0;
      unique case (op)
         LU_AND:  r = a & b;
         LU_OR:   r = a | b;
         // Inversions happen at IN_WIDTH so the zero-extended upper bits stay 0.
         LU_NAND: r = ~(a & b);
         LU_NOR:  r = ~(a | b);
         LU_XOR:  r = a ^ b;
         LU_XNOR: r = ~(a ^ b);
`ifdef LOGIC_UNIT_PIPE_SHIFT_EN
         LU_SHL:  r = a << sh;
         // Rotate via a doubled copy: the low half of {a,a}>>sh is a rotated right.
         LU_ROR:  r = IN_WIDTH'({a, a} >> sh);
`else
         LU_SHL, LU_ROR: begin
            r   = '0;
            ill = 1'b1;
         end
`endif
         default: r = '0;
      endcase
   end

   always_comb begin
      res                      = '0;
      res.data[OUT_WIDTH-1:0]  = OUT_WIDTH'(r);
      res.zero                 = (r == '0);
      res.illegal              = ill;
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Purpose : two-stage pipelined logic unit (S1 operand regs, S2 result regs) with op counter.
// Latency : op handshaken in cycle N is visible on Logic_OUT/Logic_Flag after edge N+2.
// Backpr. : holds 2 ops when out_ready is low; in_ready is combinational from out_ready.
// Ports   : clk, RST (async active-low); A, B, ALU_FUN, in_valid/in_ready on the input side;
//           Logic_OUT, Zero_Flag, Illegal_Flag, Logic_Flag (out valid)/out_ready on the output
//           side; Op_Count counts consumed results, wrapping at 2^CNT_WIDTH.
// Config  : LOGIC_UNIT_PIPE_SHIFT_EN enables SHL/ROR in logic_unit_core.
// Params  : IN_WIDTH >= 2, OUT_WIDTH >= IN_WIDTH (and < LU_MAX_W), CNT_WIDTH >= 1.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic [IN_WIDTH-1:0]  A,
   input  logic [IN_WIDTH-1:0]  B,
   input  logic [OP_W-1:0]      ALU_FUN,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] Logic_OUT,
   output logic                 Logic_Flag,
   input  logic                 out_ready,
   output logic                 Zero_Flag,
   output logic                 Illegal_Flag,
   output logic [CNT_WIDTH-1:0] Op_Count
);

   logic                s1_valid;
   logic [IN_WIDTH-1:0] s1_a;
   logic [IN_WIDTH-1:0] s1_b;
   logic [OP_W-1:0]     s1_op;

   logic       s2_loads;
   logic       s1_loads;
   lu_result_t core_res;
   logic       unused_core_hi;

   // S2 advances when empty or being drained; S1 advances when empty or emptying into S2.
   // Both can shift in the same edge, so a full pipe with out_ready high takes no bubble.
   assign s2_loads = !Logic_Flag || out_ready;
   assign s1_loads = !s1_valid || s2_loads;
   assign in_ready = s1_loads;

   logic_unit_core #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_core (
      .op  (lu_op_e'(s1_op)),
      .a   (s1_a),
      .b   (s1_b),
      .res (core_res)
   );

   // Core data above OUT_WIDTH is always zero.
   assign unused_core_hi = |core_res.data[LU_MAX_W-1:OUT_WIDTH];

   // Stage 1: operand capture.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (s1_loads) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= A;
            s1_b  <= B;
            s1_op <= ALU_FUN;
         end
      end
   end

   // Stage 2: result capture. Data regs only move on a real op so a stalled or
   // bubbled result stays bit-stable.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         Logic_Flag   <= 1'b0;
         Logic_OUT    <= '0;
         Zero_Flag    <= 1'b0;
         Illegal_Flag <= 1'b0;
      end else if (s2_loads) begin
         Logic_Flag <= s1_valid;
         if (s1_valid) begin
            Logic_OUT    <= core_res.data[OUT_WIDTH-1:0];
            Zero_Flag    <= core_res.zero;
            Illegal_Flag <= core_res.illegal;
         end
      end
   end

   // Consumed-result counter, wraps naturally.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         Op_Count <= '0;
      end else if (Logic_Flag && out_ready) begin
         Op_Count <= Op_Count + 1'b1;
      end
   end

endmodule
